// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the scanout block and the synchronous pixel RAM.
//   fb_addr : row-major read address (y*FB_WIDTH + x), driven by the scanout side
//   fb_data : {R,G,B} read data, valid one clock after fb_addr
// master = scanout (address source), slave = RAM (data source).
interface vga_scanout_if #(
    parameter int unsigned ADDR_W = 15
);
    logic [ADDR_W-1:0] fb_addr;
    logic [2:0]        fb_data;

    modport master (output fb_addr, input fb_data);
    modport slave  (input fb_addr, output fb_data);
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: reads the 3-bit framebuffer back continuously and drives the DE1
// VGA DAC at 640x480@60 Hz from a 50 MHz clock, upscaling each framebuffer pixel
// by 2^SCALE_SHIFT in both directions.
//
// Ports:
//   CLOCK_50    in   system clock, pixel rate is half of it (pix_en strobe)
//   reset       in   asynchronous, active-high
//   fb          if   framebuffer read port (master: fb_addr out, fb_data in)
//   pattern_sel in   only with TEST_PATTERN_EN: 1 selects 8 vertical colour bars
//   VGA_CLK     out  25 MHz pixel clock
//   VGA_HS/VS   out  active-low syncs
//   VGA_BLANK_N out  low during blanking
//   VGA_SYNC_N  out  constant 1
//   VGA_R/G/B   out  8-bit channels, each a replicated framebuffer bit
//   frame_done  out  one-clock pulse as the last visible line ends
//
// Optional feature macro: TEST_PATTERN_EN (adds pattern_sel and the bar generator).
//
// Pipeline: counters -> stage 1 (address + sync/blank flags) -> stage 2 (pins).
// The RAM answers between the two stages, so colour and syncs leave aligned,
// two pixel clocks after the counter value that produced them.
module vga_scanout #(
    parameter int unsigned FB_WIDTH    = 160,
    parameter int unsigned FB_HEIGHT   = 120,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    vga_scanout_if.master       fb,
`ifdef TEST_PATTERN_EN
    input  logic                pattern_sel,
`endif
    output logic                VGA_CLK,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic                VGA_BLANK_N,
    output logic                VGA_SYNC_N,
    output logic [7:0]          VGA_R,
    output logic [7:0]          VGA_G,
    output logic [7:0]          VGA_B,
    output logic                frame_done
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned H_ACTIVE = FB_WIDTH << SCALE_SHIFT;
    localparam int unsigned V_ACTIVE = FB_HEIGHT << SCALE_SHIFT;

    typedef logic [CNT_W-1:0] cnt_t;

    // Porch/sync widths are those of the 640x480@60 mode, counted from the end of
    // the visible area.
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t H_SYNC_S = cnt_t'(H_ACTIVE + 16);
    localparam cnt_t H_SYNC_E = cnt_t'(H_ACTIVE + 112);
    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + 159);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t V_SYNC_S = cnt_t'(V_ACTIVE + 10);
    localparam cnt_t V_SYNC_E = cnt_t'(V_ACTIVE + 12);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + 44);

    localparam logic [31:0] FB_WIDTH_BITS = 32'(FB_WIDTH);

    // y*FB_WIDTH as a sum of shifted copies of y, one per set bit of the
    // constant; for 160 this is (y<<7)+(y<<5).
    function automatic logic [ADDR_W-1:0] row_base(input logic [ADDR_W-1:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            if (FB_WIDTH_BITS[i]) acc = acc + (y << i);
        end
        return acc;
    endfunction

    // Pixel-rate strobe and counters
    logic        pix_en_q, vga_clk_q;
    cnt_t        hcnt_q, hcnt_d;
    cnt_t        vcnt_q, vcnt_d;

    // Stage 1
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;
    logic        blank1_q, blank1_d;
`ifdef TEST_PATTERN_EN
    logic        pat_sel1_q;
    logic [2:0]  pat_col1_q;
`endif

    // Stage 2
    logic        hs2_q, vs2_q, blank_n2_q;
    logic [2:0]  col2_q, col2_d;

    cnt_t        fb_x, fb_y;
    logic        visible;

    always_comb begin
        hcnt_d = hcnt_q + cnt_t'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + cnt_t'(1);
        end
    end

    always_comb begin
        fb_x     = hcnt_q >> SCALE_SHIFT;
        fb_y     = vcnt_q >> SCALE_SHIFT;
        visible  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        addr_d   = visible ? row_base(ADDR_W'(fb_y)) + ADDR_W'(fb_x) : '0;
        hs1_d    = !((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E));
        vs1_d    = !((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E));
        blank1_d = !visible;
    end

    // fb_data is read here, one CLOCK_50 after the RAM registered addr_q.
    always_comb begin
        col2_d = fb.fb_data;
`ifdef TEST_PATTERN_EN
        if (pat_sel1_q) col2_d = pat_col1_q;
`endif
        if (blank1_q) col2_d = '0;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pix_en_q   <= 1'b0;
            vga_clk_q  <= 1'b0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            addr_q     <= '0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            blank1_q   <= 1'b1;
`ifdef TEST_PATTERN_EN
            pat_sel1_q <= 1'b0;
            pat_col1_q <= '0;
`endif
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            blank_n2_q <= 1'b0;
            col2_q     <= '0;
        end else begin
            pix_en_q  <= ~pix_en_q;
            vga_clk_q <= pix_en_q;
            if (pix_en_q) begin
                hcnt_q     <= hcnt_d;
                vcnt_q     <= vcnt_d;
                addr_q     <= addr_d;
                hs1_q      <= hs1_d;
                vs1_q      <= vs1_d;
                blank1_q   <= blank1_d;
`ifdef TEST_PATTERN_EN
                pat_sel1_q <= pattern_sel;
                pat_col1_q <= hcnt_q[8:6];
`endif
                hs2_q      <= hs1_q;
                vs2_q      <= vs1_q;
                blank_n2_q <= ~blank1_q;
                col2_q     <= col2_d;
            end
        end
    end

    assign fb.fb_addr  = addr_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs2_q;
    assign VGA_VS      = vs2_q;
    assign VGA_BLANK_N = blank_n2_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_R       = {8{col2_q[2]}};
    assign VGA_G       = {8{col2_q[1]}};
    assign VGA_B       = {8{col2_q[0]}};

    // High only during the pix_en cycle in which vcnt steps to the first blank line.
    assign frame_done  = pix_en_q && (hcnt_q == H_LAST) && (vcnt_q == V_ACT - cnt_t'(1));

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout. Two instances share the clock, reset and a random
// framebuffer: "a" uses the full 160x120 geometry (line timing, addressing,
// colour, mid-line reset); "b" uses a 16x8 framebuffer so whole frames fit in
// the run (vertical sync, frame_done period). Expected outputs come from a
// position model: after posedge number e since reset release, the stage-1
// address belongs to screen position e/2-1 and the pins to e/2-2.
module tb_vga_scanout;

    localparam int AW = 15;
    localparam int SW = 16;
    localparam int SH = 8;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    logic pattern_sel = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    vga_scanout_if #(.ADDR_W(AW)) fb_a ();
    vga_scanout_if #(.ADDR_W(AW)) fb_b ();

    logic       clk_a, hs_a, vs_a, bn_a, sn_a, fd_a;
    logic [7:0] r_a, g_a, b_a;
    logic       clk_b, hs_b, vs_b, bn_b, sn_b, fd_b;
    logic [7:0] r_b, g_b, b_b;

    vga_scanout dut_a (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .fb          (fb_a),
`ifdef TEST_PATTERN_EN
        .pattern_sel (pattern_sel),
`endif
        .VGA_CLK     (clk_a),
        .VGA_HS      (hs_a),
        .VGA_VS      (vs_a),
        .VGA_BLANK_N (bn_a),
        .VGA_SYNC_N  (sn_a),
        .VGA_R       (r_a),
        .VGA_G       (g_a),
        .VGA_B       (b_a),
        .frame_done  (fd_a)
    );

    vga_scanout #(.FB_WIDTH(SW), .FB_HEIGHT(SH)) dut_b (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .fb          (fb_b),
`ifdef TEST_PATTERN_EN
        .pattern_sel (pattern_sel),
`endif
        .VGA_CLK     (clk_b),
        .VGA_HS      (hs_b),
        .VGA_VS      (vs_b),
        .VGA_BLANK_N (bn_b),
        .VGA_SYNC_N  (sn_b),
        .VGA_R       (r_b),
        .VGA_G       (g_b),
        .VGA_B       (b_b),
        .frame_done  (fd_b)
    );

    // Framebuffer RAM model: synchronous read, one clock of latency.
    logic [2:0] mem [0:19199];
    always @(posedge CLOCK_50) begin
        fb_a.fb_data <= (fb_a.fb_addr < 15'd19200) ? mem[fb_a.fb_addr] : 3'b000;
        fb_b.fb_data <= (fb_b.fb_addr < 15'd19200) ? mem[fb_b.fb_addr] : 3'b000;
    end

    int   n_pass  = 0;
    int   n_total = 0;
    int   e       = 0;
    logic sel_hist [0:32767];

    int hs_fall1, hs_fall2, hs_rise1, vs_fall1, vs_rise1, fd1, fd2;
    logic hs_prev, vs_prev;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, e, obs, expv);
    endtask

    function automatic logic [14:0] addr_of(input int q, input int fbw, input int fbh);
        int ht = fbw * 4 + 160;
        int vt = fbh * 4 + 45;
        int h  = q % ht;
        int v  = (q / ht) % vt;
        if (q >= 0 && h < fbw * 4 && v < fbh * 4) return 15'((v / 4) * fbw + h / 4);
        return 15'd0;
    endfunction

    task automatic check_inst(input string nm, input int fbw, input int fbh,
                              input logic [14:0] addr, input logic [4:0] flags,
                              input logic [23:0] rgb, input logic fd);
        int ha = fbw * 4;
        int va = fbh * 4;
        int ht = ha + 160;
        int vt = va + 45;
        int q2 = e / 2 - 2;
        int c  = (e + 1) / 2 - 1;
        int h, v;
        logic exp_clk, efd;
        logic [4:0]  ef;
        logic [23:0] er;
        logic [2:0]  col;
        exp_clk = (e == 0) ? 1'b0 : ((e - 1) % 2 == 1);
        if (q2 < 0) begin
            ef = {exp_clk, 1'b1, 1'b1, 1'b0, 1'b1};
            er = 24'h0;
        end else begin
            h  = q2 % ht;
            v  = (q2 / ht) % vt;
            ef = {exp_clk, !(h >= ha + 16 && h < ha + 112), !(v >= va + 10 && v < va + 12),
                  (h < ha && v < va), 1'b1};
            if (h < ha && v < va) begin
                col = sel_hist[q2] ? 3'((h >> 6) & 7) : mem[addr_of(q2, fbw, fbh)];
                er  = {{8{col[2]}}, {8{col[1]}}, {8{col[0]}}};
            end else begin
                er = 24'h0;
            end
        end
        efd = (e % 2 == 1) && (c % ht == ht - 1) && ((c / ht) % vt == va - 1);
        check({nm, "_addr"},  64'(addr),  64'(addr_of(e / 2 - 1, fbw, fbh)));
        check({nm, "_flags"}, 64'(flags), 64'(ef));
        check({nm, "_rgb"},   64'(rgb),   64'(er));
        check({nm, "_frame_done"}, 64'(fd), 64'(efd));
    endtask

    task automatic clear_meas();
        hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1;
        vs_fall1 = -1; vs_rise1 = -1; fd1 = -1; fd2 = -1;
        hs_prev = 1'b1; vs_prev = 1'b1;
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        if (reset) begin
            e = 0;
        end else begin
            e++;
            if (e % 2 == 0 && e / 2 - 1 < 32768) sel_hist[e / 2 - 1] = pattern_sel;
        end
        @(negedge CLOCK_50);
        check_inst("a", 160, 120, fb_a.fb_addr, {clk_a, hs_a, vs_a, bn_a, sn_a},
                   {r_a, g_a, b_a}, fd_a);
        check_inst("b", SW, SH, fb_b.fb_addr, {clk_b, hs_b, vs_b, bn_b, sn_b},
                   {r_b, g_b, b_b}, fd_b);
        if (!reset) begin
            // Screen pixel (16,4) reads framebuffer (4,1).
            if (e == 2 * (4 * 800 + 16 + 1)) check("addr_164", 64'(fb_a.fb_addr), 64'd164);
            // Pixel (5,5) lies in the 4x4 block fed by address 161 = 3'b101.
            if (e == 2 * (5 * 800 + 5 + 2) && !sel_hist[5 * 800 + 5])
                check("block_161_rgb", 64'({r_a, g_a, b_a}), 64'h00FF00FF);
            if (hs_prev && !hs_a) begin
                if (hs_fall1 < 0) hs_fall1 = e;
                else if (hs_fall2 < 0) hs_fall2 = e;
            end
            if (!hs_prev && hs_a && hs_fall1 >= 0 && hs_rise1 < 0) hs_rise1 = e;
            if (vs_prev && !vs_b && vs_fall1 < 0) vs_fall1 = e;
            if (!vs_prev && vs_b && vs_fall1 >= 0 && vs_rise1 < 0) vs_rise1 = e;
            if (fd_b) begin
                if (fd1 < 0) fd1 = e;
                else if (fd2 < 0) fd2 = e;
            end
        end
        hs_prev = hs_a;
        vs_prev = vs_b;
`ifdef TEST_PATTERN_EN
        pattern_sel = 1'($urandom);
`endif
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);
        for (int i = 0; i < 32768; i++) sel_hist[i] = 1'b0;
        mem[161] = 3'b101;
        clear_meas();

        // Power-up reset, then run into line 1 of instance a.
        repeat (3) step();
        reset = 1'b0;
        while (e < 2 * (800 + 300)) step();

        // Reset in the middle of line 1 (hcnt=300) for three clocks.
        reset = 1'b1;
        #1;
        check("midreset_hs",      64'(hs_a), 64'd1);
        check("midreset_blank_n", 64'(bn_a), 64'd0);
        check("midreset_addr",    64'(fb_a.fb_addr), 64'd0);
        repeat (3) step();
        reset = 1'b0;
        clear_meas();

        // Long enough for instance b to finish two frames.
        repeat (50000) step();

        check("hs_first_fall", 64'(hs_fall1), 64'(656 * 2 + 4));
        check("hs_period",     64'(hs_fall2 - hs_fall1), 64'd1600);
        check("hs_width",      64'(hs_rise1 - hs_fall1), 64'd192);
        check("b_vs_width",    64'(vs_rise1 - vs_fall1), 64'(2 * 2 * (SW * 4 + 160)));
        check("b_fd_first",    64'(fd1), 64'(2 * (SH * 4 * (SW * 4 + 160) - 1) + 1));
        check("b_fd_period",   64'(fd2 - fd1),
              64'(2 * (SW * 4 + 160) * (SH * 4 + 45)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
